// File: rtl/writeback_unit_if.sv
// Register-file writeback bus: ALU retire, load issue/completion and the
// single register-file write port.
//   master : upstream/memory side (drives ALU, load and memory signals)
//   slave  : writeback_unit side (drives load status, stall and write port)
interface writeback_unit_if;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_result;
   logic        load_issue;
   logic [4:0]  load_rd;
   logic [2:0]  load_funct3;
   logic [1:0]  load_addr_lo;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        load_ready;
   logic        load_pending;
   logic [4:0]  load_pending_rd;
   logic        alu_stall;
   logic [4:0]  rd_address;
   logic        register_write_en;
   logic [31:0] register_write_data;

   modport master (
      output alu_valid, alu_rd, alu_result,
      output load_issue, load_rd, load_funct3, load_addr_lo,
      output mem_ack, mem_rdata,
      input  load_ready, load_pending, load_pending_rd, alu_stall,
      input  rd_address, register_write_en, register_write_data
   );

   modport slave (
      input  alu_valid, alu_rd, alu_result,
      input  load_issue, load_rd, load_funct3, load_addr_lo,
      input  mem_ack, mem_rdata,
      output load_ready, load_pending, load_pending_rd, alu_stall,
      output rd_address, register_write_en, register_write_data
   );
endinterface

// File: rtl/writeback_unit.sv
// Writer side of the RV32 integer register file. Serialises single-cycle ALU
// results and multi-cycle load completions onto one registered write port,
// extends load data per funct3, and tracks one outstanding load.
// Ports:
//   clk  : system clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : writeback_unit_if.slave (ALU/load/memory inputs, load status,
//          alu_stall and the rd_address/register_write_en/data write port)
module writeback_unit (
   input logic            clk,
   input logic            rst,
   writeback_unit_if.slave bus
);

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t      state_q;
   logic [4:0]  ld_rd_q;
   logic [2:0]  ld_funct3_q;
   logic [1:0]  ld_lo_q;
   logic        kill_q;
   logic        buf_valid_q;
   logic [4:0]  buf_rd_q;
   logic [31:0] buf_data_q;
   logic        load_ready_q;
   logic        load_pending_q;
   logic [4:0]  load_pending_rd_q;
   logic        wr_en_q;
   logic [4:0]  wr_rd_q;
   logic [31:0] wr_data_q;

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data_d;
   logic        load_done;
   logic        load_writes;
   logic        alu_accept;
   logic        alu_writes;

   always_comb begin
      byte_sel = '0;
      case (ld_lo_q)
         2'd0:    byte_sel = bus.mem_rdata[7:0];
         2'd1:    byte_sel = bus.mem_rdata[15:8];
         2'd2:    byte_sel = bus.mem_rdata[23:16];
         default: byte_sel = bus.mem_rdata[31:24];
      endcase
      half_sel = ld_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

      load_data_d = bus.mem_rdata;
      case (ld_funct3_q)
         3'b000:  load_data_d = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_data_d = {24'd0, byte_sel};
         3'b001:  load_data_d = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_data_d = {16'd0, half_sel};
         default: load_data_d = bus.mem_rdata;
      endcase

      load_done   = (state_q == WAIT_MEM) && bus.mem_ack;
      load_writes = load_done && !kill_q && (ld_rd_q != '0);
      // The hold buffer being full is exactly the stall condition.
      alu_accept  = bus.alu_valid && !buf_valid_q;
      alu_writes  = alu_accept && (bus.alu_rd != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         ld_rd_q           <= '0;
         ld_funct3_q       <= '0;
         ld_lo_q           <= '0;
         kill_q            <= 1'b0;
         buf_valid_q       <= 1'b0;
         buf_rd_q          <= '0;
         buf_data_q        <= '0;
         load_ready_q      <= 1'b1;
         load_pending_q    <= 1'b0;
         load_pending_rd_q <= '0;
         wr_en_q           <= 1'b0;
         wr_rd_q           <= '0;
         wr_data_q         <= '0;
      end else begin
         wr_en_q     <= 1'b0;
         wr_rd_q     <= '0;
         wr_data_q   <= '0;
         buf_valid_q <= 1'b0;

         // A load can never complete while the buffer is full: the buffer is
         // only filled on a completion, which returns the FSM to IDLE.
         if (buf_valid_q) begin
            wr_en_q   <= 1'b1;
            wr_rd_q   <= buf_rd_q;
            wr_data_q <= buf_data_q;
         end else if (load_writes) begin
            wr_en_q   <= 1'b1;
            wr_rd_q   <= ld_rd_q;
            wr_data_q <= load_data_d;
            if (alu_writes) begin
               buf_valid_q <= 1'b1;
               buf_rd_q    <= bus.alu_rd;
               buf_data_q  <= bus.alu_result;
            end
         end else if (alu_writes) begin
            wr_en_q   <= 1'b1;
            wr_rd_q   <= bus.alu_rd;
            wr_data_q <= bus.alu_result;
         end

         case (state_q)
            IDLE: begin
               if (bus.load_issue) begin
                  state_q           <= WAIT_MEM;
                  ld_rd_q           <= bus.load_rd;
                  ld_funct3_q       <= bus.load_funct3;
                  ld_lo_q           <= bus.load_addr_lo;
                  kill_q            <= 1'b0;
                  load_ready_q      <= 1'b0;
                  load_pending_q    <= 1'b1;
                  load_pending_rd_q <= bus.load_rd;
               end
            end
            WAIT_MEM: begin
               if (bus.mem_ack) begin
                  state_q           <= IDLE;
                  kill_q            <= 1'b0;
                  load_ready_q      <= 1'b1;
                  load_pending_q    <= 1'b0;
                  load_pending_rd_q <= '0;
               end else if (alu_accept && (bus.alu_rd == ld_rd_q) && (ld_rd_q != '0)) begin
                  // Younger ALU write to the same rd makes the load result dead.
                  kill_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.load_ready          = load_ready_q;
   assign bus.load_pending        = load_pending_q;
   assign bus.load_pending_rd     = load_pending_rd_q;
   assign bus.alu_stall           = buf_valid_q;
   assign bus.rd_address          = wr_rd_q;
   assign bus.register_write_en   = wr_en_q;
   assign bus.register_write_data = wr_data_q;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   writeback_unit_if bus ();

   writeback_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   bit          mon_on = 1'b0;

   // Write-port monitor: every write must match the oldest scoreboard entry,
   // including the edge at which it was expected; idle cycles must read 0.
   always begin
      @(posedge clk);
      cyc++;
      #1;
      if (mon_on) begin
         if (bus.register_write_en === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
               errors++;
               $error("FAIL unexpected_write observed rd=%0d data=%h expected no write", bus.rd_address, bus.register_write_data);
            end
            if (sb.size() > 0) begin
               e = sb.pop_front();
               checks++;
               assert (bus.rd_address === e.rd) else begin
                  errors++;
                  $error("FAIL write_rd observed=%0d expected=%0d", bus.rd_address, e.rd);
               end
               checks++;
               assert (bus.register_write_data === e.data) else begin
                  errors++;
                  $error("FAIL write_data observed=%h expected=%h", bus.register_write_data, e.data);
               end
               checks++;
               assert (cyc === e.cyc) else begin
                  errors++;
                  $error("FAIL write_cycle observed=%0d expected=%0d", cyc, e.cyc);
               end
            end
         end else begin
            checks++;
            assert ({bus.register_write_en, bus.rd_address, bus.register_write_data} === 38'd0) else begin
               errors++;
               $error("FAIL idle_port observed en=%b rd=%0d data=%h expected all 0", bus.register_write_en, bus.rd_address, bus.register_write_data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] data, input int unsigned dly);
      exp_t t;
      t.rd   = rd;
      t.data = data;
      t.cyc  = cyc + dly;
      sb.push_back(t);
   endtask

   task automatic clear_inputs();
      bus.alu_valid    = 1'b0;
      bus.alu_rd       = '0;
      bus.alu_result   = '0;
      bus.load_issue   = 1'b0;
      bus.load_rd      = '0;
      bus.load_funct3  = '0;
      bus.load_addr_lo = '0;
      bus.mem_ack      = 1'b0;
      bus.mem_rdata    = '0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
      bus.load_issue   = 1'b1;
      bus.load_rd      = rd;
      bus.load_funct3  = f3;
      bus.load_addr_lo = lo;
      tick();
      bus.load_issue   = 1'b0;
      chk("pending", bus.load_pending, 1);
      chk("pending_rd", bus.load_pending_rd, rd);
      chk("ready_wait", bus.load_ready, 0);
   endtask

   task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                          input logic [31:0] rdata, input logic [31:0] exp);
      issue(rd, f3, lo);
      tick();
      chk("pending_hold", bus.load_pending, 1);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rdata;
      if (rd != '0) push(rd, exp, 1);
      tick();
      bus.mem_ack = 1'b0;
      chk("ready_done", bus.load_ready, 1);
      chk("pending_done", bus.load_pending, 0);
      chk("pending_rd_done", bus.load_pending_rd, 0);
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_wen", bus.register_write_en, 0);
      chk("rst_rd", bus.rd_address, 0);
      chk("rst_data", bus.register_write_data, 0);
      chk("rst_ready", bus.load_ready, 1);
      chk("rst_pending", bus.load_pending, 0);
      chk("rst_pending_rd", bus.load_pending_rd, 0);
      chk("rst_stall", bus.alu_stall, 0);
      rst    = 1'b0;
      mon_on = 1'b1;

      // ALU write, then an x0 ALU write that must be suppressed
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_result = 32'hDEADBEEF;
      push(5'd5, 32'hDEADBEEF, 1);
      tick();
      bus.alu_rd = 5'd0; bus.alu_result = 32'h12345678;
      tick();
      bus.alu_valid = 1'b0;
      tick();

      // Load extension cases
      do_load(5'd7,  3'b000, 2'd3, 32'h80112233, 32'hFFFFFF80);
      do_load(5'd10, 3'b101, 2'd2, 32'h80011234, 32'h00008001);
      do_load(5'd11, 3'b001, 2'd2, 32'h80011234, 32'hFFFF8001);
      do_load(5'd12, 3'b001, 2'd3, 32'h80011234, 32'hFFFF8001);
      do_load(5'd13, 3'b100, 2'd1, 32'h0000A500, 32'h000000A5);
      do_load(5'd14, 3'b000, 2'd0, 32'h0000007F, 32'h0000007F);
      do_load(5'd15, 3'b010, 2'd1, 32'hCAFEF00D, 32'hCAFEF00D);
      do_load(5'd16, 3'b011, 2'd2, 32'h0BADC0DE, 32'h0BADC0DE);
      do_load(5'd0,  3'b010, 2'd0, 32'hFFFFFFFF, 32'h0);

      // Collision: load wins, ALU buffered; held ALU request rejected while stalled
      issue(5'd3, 3'b010, 2'd0);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_result = 32'h22;
      push(5'd3, 32'h11, 1);
      push(5'd4, 32'h22, 2);
      tick();
      bus.mem_ack = 1'b0;
      bus.alu_rd = 5'd6; bus.alu_result = 32'h99;
      chk("stall_set", bus.alu_stall, 1);
      tick();
      chk("stall_clear", bus.alu_stall, 0);
      push(5'd6, 32'h99, 1);
      tick();
      bus.alu_valid = 1'b0;
      tick();

      // WAW kill: only the ALU write to x9 survives
      issue(5'd9, 3'b010, 2'd0);
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_result = 32'h55;
      push(5'd9, 32'h55, 1);
      tick();
      bus.alu_valid = 1'b0;
      tick();
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAAAA;
      tick();
      bus.mem_ack = 1'b0;
      chk("kill_ready", bus.load_ready, 1);
      do_load(5'd9, 3'b010, 2'd0, 32'h77, 32'h77);

      // Load issue and ALU retire together in IDLE
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd21; bus.alu_result = 32'h33;
      push(5'd21, 32'h33, 1);
      issue(5'd20, 3'b010, 2'd0);
      bus.alu_valid = 1'b0;
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h44;
      push(5'd20, 32'h44, 1);
      tick();
      bus.mem_ack = 1'b0;

      // Reset during WAIT_MEM abandons the load; later mem_ack ignored
      issue(5'd22, 3'b010, 2'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_ready", bus.load_ready, 1);
      chk("midrst_pending", bus.load_pending, 0);
      chk("midrst_pending_rd", bus.load_pending_rd, 0);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h123;
      tick();
      bus.mem_ack = 1'b0;
      chk("idle_ack_ready", bus.load_ready, 1);
      tick();
      tick();
      tick();
      chk("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
